ifu: RTL and testbench

Instruction fetch unit: the producing end of the IF/ID pipeline register. Owns the program counter and issues in-order word fetches on a request/grant instruction bus. It buffers returned instructions in a small FIFO and presents one {pc, instr} pair per cycle to the IF/ID register. A redirect from the execute stage (jump/branch taken) squashes buffered and in-flight fetches and restarts fetching at the target.

---
 rtl/ifu_pkg.sv | 12 +
 rtl/ifu_fifo.sv | 56 +++++
 rtl/ifu.sv | 94 +++++++++
 tb/tb_ifu.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset defaults and the fetch record for the instruction fetch unit
package ifu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] BUBBLE = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with clear, occupancy count and empty/full flags
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int W = XLEN,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;

    // pointer and occupancy update; clear wins over push and pop
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(do_pop);
        count_d = clear ? '0 : count_q + CW'(do_push) - CW'(do_pop);
        dout = mem_q[rd_ptr_q];
        count = count_q;
        empty = count_q == '0;
        full = count_q == CW'(DEPTH);
    end

    // pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit issuing in-order word fetches and feeding the IF/ID register
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            hold,
    output logic            ibus_req,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_gnt,
    input  logic            ibus_rvalid,
    input  logic [XLEN-1:0] ibus_rdata,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
    logic [CW:0] in_flight;
    logic grant, keep, pop;
    fetch_t fifo_din, fifo_dout;
    logic [CW-1:0] fifo_count, pend_count;
    logic fifo_empty, fifo_full, pend_empty, pend_full;
    logic [XLEN-1:0] pend_pc;
    logic unused_flags;

    // request credit, response routing, output muxing and next-state values
    always_comb begin
        in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};
        ibus_req = rst_n && !jump_en && (in_flight < DEPTH_C);
        ibus_addr = pc_q;
        grant = ibus_req && ibus_gnt;
        keep = ibus_rvalid && !jump_en && (discard_q == '0) && !pend_empty;
        instr_valid_o = !fifo_empty && !jump_en;
        pop = instr_valid_o && !hold;
        instr_o = instr_valid_o ? fifo_dout.instr : BUBBLE;
        pc_o = instr_valid_o ? fifo_dout.pc : BUBBLE;
        fifo_din.pc = pend_pc;
        fifo_din.instr = ibus_rdata;
        outstanding_d = outstanding_q + CW'(grant) - CW'(ibus_rvalid);
        discard_d = jump_en ? outstanding_d : discard_q - CW'(ibus_rvalid && (discard_q != '0));
        pc_d = jump_en ? jump_addr : grant ? pc_q + PC_STEP : pc_q;
        unused_flags = ^{fifo_full, pend_full, pend_count};
    end

    // program counter and bus bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            outstanding_q <= '0;
            discard_q <= '0;
        end else begin
            pc_q <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q <= discard_d;
        end
    end

    // addresses of granted fetches still awaiting their (non-discarded) response
    ifu_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pend (
        .clk(clk),
        .rst_n(rst_n),
        .push(grant),
        .pop(keep),
        .clear(jump_en),
        .din(pc_q),
        .dout(pend_pc),
        .count(pend_count),
        .empty(pend_empty),
        .full(pend_full)
    );

    // prefetch buffer of {pc, instr} pairs presented to IF/ID
    ifu_fifo #(.W($bits(fetch_t)), .DEPTH(DEPTH)) u_fetch (
        .clk(clk),
        .rst_n(rst_n),
        .push(keep),
        .pop(pop),
        .clear(jump_en),
        .din(fifo_din),
        .dout(fifo_dout),
        .count(fifo_count),
        .empty(fifo_empty),
        .full(fifo_full)
    );
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed self-checking bench for the instruction fetch unit
module tb_ifu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic hold = 1'b0;
    logic ibus_req;
    logic [31:0] ibus_addr;
    logic ibus_gnt = 1'b1;
    logic ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int grants = 0;
    int pops = 0;
    int mark = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] q_addr [$];
    int q_due [$];

    always #5 clk = ~clk;

    ifu #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .jump_en(jump_en),
        .jump_addr(jump_addr),
        .hold(hold),
        .ibus_req(ibus_req),
        .ibus_addr(ibus_addr),
        .ibus_gnt(ibus_gnt),
        .ibus_rvalid(ibus_rvalid),
        .ibus_rdata(ibus_rdata),
        .instr_valid_o(instr_valid_o),
        .instr_o(instr_o),
        .pc_o(pc_o)
    );

    // in-order bus slave: a grant taken with latency lat answers lat cycles later, one per cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            ibus_rvalid = 1'b0;
            ibus_rdata = '0;
        end else begin
            cyc++;
            if (ibus_req && ibus_gnt) begin
                q_addr.push_back(ibus_addr);
                q_due.push_back(cyc + lat - 1);
                grants++;
            end
            #1;
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                ibus_rvalid = 1'b1;
                ibus_rdata = q_addr.pop_front() ^ 32'hA5A5_0000;
                void'(q_due.pop_front());
            end else begin
                ibus_rvalid = 1'b0;
                ibus_rdata = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // finish the current cycle: a consumed pair must be the next address in sequence
    task automatic step();
        #1;
        if (instr_valid_o && !hold) begin
            check("stream_pc", pc_o, exp_pc);
            check("stream_instr", instr_o, exp_pc ^ 32'hA5A5_0000);
            exp_pc += 32'd4;
            pops++;
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, ibus_req}, 32'd0);
        check("rst_addr", ibus_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);

        rst_n = 1'b1;
        #1;
        check("first_req", {31'b0, ibus_req}, 32'd1);
        check("first_addr", ibus_addr, 32'h0);
        check("c1_valid", {31'b0, instr_valid_o}, 32'd0);
        step();
        check("c2_valid", {31'b0, instr_valid_o}, 32'd0);
        check("c2_addr", ibus_addr, 32'h4);
        step();
        check("c3_valid", {31'b0, instr_valid_o}, 32'd1);
        check("c3_addr", ibus_addr, 32'h8);
        step();
        repeat (6) step();
        check("pops_pre_hold", 32'(pops), 32'd7);

        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", {31'b0, instr_valid_o}, 32'd1);
            check("hold_pc", pc_o, exp_pc);
            check("hold_instr", instr_o, exp_pc ^ 32'hA5A5_0000);
            check("hold_req", {31'b0, ibus_req}, (i < 2) ? 32'd1 : 32'd0);
            step();
        end
        hold = 1'b0;
        repeat (8) step();
        check("pops_post_hold", 32'(pops), 32'd15);
        check("exp_post_hold", exp_pc, 32'd60);

        lat = 4;
        step();
        step();
        ibus_gnt = 1'b0;
        jump_en = 1'b1;
        jump_addr = 32'h0000_0100;
        #1;
        check("jump_valid", {31'b0, instr_valid_o}, 32'd0);
        check("jump_instr", instr_o, 32'h0);
        check("jump_req", {31'b0, ibus_req}, 32'd0);
        step();
        jump_en = 1'b0;
        lat = 1;
        exp_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gntlow_req", {31'b0, ibus_req}, 32'd1);
            check("gntlow_addr", ibus_addr, 32'h100);
            step();
        end
        mark = grants;
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0;
        #1;
        check("one_grant", 32'(grants - mark), 32'd1);
        check("after_grant_addr", ibus_addr, 32'h104);
        check("after_grant_req", {31'b0, ibus_req}, 32'd1);
        step();
        ibus_gnt = 1'b1;
        mark = pops;
        repeat (8) step();
        check("jump_progress", {31'b0, (pops - mark) >= 4}, 32'd1);
        check("jump_first_done", {31'b0, exp_pc > 32'h100}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            lat = $urandom_range(1, 4);
            step();
        end
        jump_en = 1'b1;
        jump_addr = 32'h0000_0200;
        step();
        jump_addr = 32'h0000_0300;
        step();
        jump_en = 1'b0;
        exp_pc = 32'h0000_0300;
        mark = pops;
        for (int i = 0; i < 30; i++) begin
            lat = $urandom_range(1, 4);
            step();
        end
        check("jump2_progress", {31'b0, (pops - mark) >= 5}, 32'd1);

        lat = 1;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("arst_instr", instr_o, 32'h0);
        check("arst_pc", pc_o, 32'h0);
        check("arst_req", {31'b0, ibus_req}, 32'd0);
        check("arst_addr", ibus_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0;
        #1;
        check("rerun_req", {31'b0, ibus_req}, 32'd1);
        check("rerun_addr", ibus_addr, 32'h0);
        mark = pops;
        repeat (10) step();
        check("rerun_progress", 32'(pops - mark), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
